// File: rtl/and_delay_meter_pkg.sv
// Shared definitions for the AND-gate delay meter.
//   NUM_VARIANTS : number of ring oscillators (four AND variants x three hold styles)
//   SEL_W        : width of the variant select
//   state_t      : measurement FSM states
//   PA_H1..PD_H20: variant indices, index = 3*p + h
package and_delay_meter_pkg;

    localparam int NUM_VARIANTS = 12;
    localparam int SEL_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } state_t;

    localparam logic [SEL_W-1:0] PA_H1  = 4'd0;
    localparam logic [SEL_W-1:0] PA_H5  = 4'd1;
    localparam logic [SEL_W-1:0] PA_H20 = 4'd2;
    localparam logic [SEL_W-1:0] PB_H1  = 4'd3;
    localparam logic [SEL_W-1:0] PB_H5  = 4'd4;
    localparam logic [SEL_W-1:0] PB_H20 = 4'd5;
    localparam logic [SEL_W-1:0] PC_H1  = 4'd6;
    localparam logic [SEL_W-1:0] PC_H5  = 4'd7;
    localparam logic [SEL_W-1:0] PC_H20 = 4'd8;
    localparam logic [SEL_W-1:0] PD_H1  = 4'd9;
    localparam logic [SEL_W-1:0] PD_H5  = 4'd10;
    localparam logic [SEL_W-1:0] PD_H20 = 4'd11;

    // True when s names an existing oscillator.
    function automatic logic is_valid_sel(input logic [SEL_W-1:0] s);
        return (s <= PD_H20);
    endfunction

    // One-hot enable word for oscillator s.
    function automatic logic [NUM_VARIANTS-1:0] onehot_en(input logic [SEL_W-1:0] s);
        logic [NUM_VARIANTS-1:0] one;
        one = {{(NUM_VARIANTS-1){1'b0}}, 1'b1};
        return one << s;
    endfunction

endpackage

// File: rtl/and_delay_meter_if.sv
// Request/result bundle of the delay meter.
//   master: drives sel, window, start; observes busy, done, count, ovf, err
//   slave : the meter itself
interface and_delay_meter_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) ();
    logic [and_delay_meter_pkg::SEL_W-1:0] sel;
    logic [WIN_W-1:0]                      window;
    logic                                  start;
    logic                                  busy;
    logic                                  done;
    logic [CNT_W-1:0]                      count;
    logic                                  ovf;
    logic                                  err;

    modport master (
        output sel, window, start,
        input  busy, done, count, ovf, err
    );

    modport slave (
        input  sel, window, start,
        output busy, done, count, ovf, err
    );
endinterface

// File: rtl/and_delay_meter_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous bit.
//   clk, rst_n : clock and asynchronous active-low reset
//   d          : asynchronous input
//   rise       : high for one clk cycle per synchronized 0->1 transition
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic meta_reg;
    logic sync_reg;
    logic sync_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg   <= 1'b0;
            sync_reg   <= 1'b0;
            sync_d_reg <= 1'b0;
        end else begin
            meta_reg   <= d;
            sync_reg   <= meta_reg;
            sync_d_reg <= sync_reg;
        end
    end

    assign rise = sync_reg & ~sync_d_reg;
endmodule

// File: rtl/and_delay_meter.sv
// Measures the frequency of one of twelve AND-gate ring oscillators by
// counting its rising edges over a programmable number of clk cycles.
//   clk, rst_n : clock and asynchronous active-low reset
//   ro_in      : oscillator outputs (asynchronous)
//   ro_en      : one-hot oscillator enables
//   bus        : request (sel, window, start) and result (busy, done, count, ovf, err)
module and_delay_meter
    import and_delay_meter_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_VARIANTS-1:0] ro_in,
    output logic [NUM_VARIANTS-1:0] ro_en,
    and_delay_meter_if.slave        bus
);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t                  state_reg;
    logic [SEL_W-1:0]        sel_reg;
    logic [WIN_W-1:0]        win_reg;
    logic [WIN_W-1:0]        win_cnt_reg;
    logic [SET_W-1:0]        settle_cnt_reg;
    logic [CNT_W-1:0]        edge_cnt_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    ovf_reg;
    logic                    err_reg;
    logic                    done_reg;
    logic                    busy_reg;
    logic                    rej_reg;
    logic [NUM_VARIANTS-1:0] ro_en_reg;

    logic osc_sel;
    logic osc_rise;
    logic start_ok;

    // Select mux uses the latched index so later changes on sel cannot
    // disturb a running measurement.
    assign osc_sel = ro_in[sel_reg];

    sync_edge u_sync_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (osc_sel),
        .rise (osc_rise)
    );

    // A start coinciding with done is dropped; the FSM is already back in
    // IDLE then, so done_reg must be part of the guard.
    assign start_ok = bus.start && !busy_reg && !done_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            win_reg        <= '0;
            win_cnt_reg    <= '0;
            settle_cnt_reg <= '0;
            edge_cnt_reg   <= '0;
            count_reg      <= '0;
            ovf_reg        <= 1'b0;
            err_reg        <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            rej_reg        <= 1'b0;
            ro_en_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        if (is_valid_sel(bus.sel)) begin
                            sel_reg        <= bus.sel;
                            win_reg        <= bus.window;
                            ro_en_reg      <= onehot_en(bus.sel);
                            busy_reg       <= 1'b1;
                            settle_cnt_reg <= SET_W'(SETTLE_CYC - 1);
                            state_reg      <= SETTLE;
                        end else begin
                            // Rejected request: the result is published on
                            // this very edge, REPORT only returns to IDLE.
                            count_reg <= '0;
                            ovf_reg   <= 1'b0;
                            err_reg   <= 1'b1;
                            done_reg  <= 1'b1;
                            rej_reg   <= 1'b1;
                            state_reg <= REPORT;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt_reg == '0) begin
                        // Clearing here discards any rises seen while the
                        // oscillator was still starting up.
                        edge_cnt_reg <= '0;
                        if (win_reg == '0) begin
                            ro_en_reg <= '0;
                            state_reg <= REPORT;
                        end else begin
                            win_cnt_reg <= win_reg - WIN_W'(1);
                            state_reg   <= MEASURE;
                        end
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - SET_W'(1);
                    end
                end
                MEASURE: begin
                    if (osc_rise && (edge_cnt_reg != '1)) begin
                        edge_cnt_reg <= edge_cnt_reg + CNT_W'(1);
                    end
                    if (win_cnt_reg == '0) begin
                        ro_en_reg <= '0;
                        state_reg <= REPORT;
                    end else begin
                        win_cnt_reg <= win_cnt_reg - WIN_W'(1);
                    end
                end
                REPORT: begin
                    if (!rej_reg) begin
                        count_reg <= edge_cnt_reg;
                        // Counter only stops at all-ones by saturating.
                        ovf_reg   <= &edge_cnt_reg;
                        err_reg   <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                    busy_reg  <= 1'b0;
                    rej_reg   <= 1'b0;
                    ro_en_reg <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ro_en     = ro_en_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.count = count_reg;
    assign bus.ovf   = ovf_reg;
    assign bus.err   = err_reg;
endmodule

// File: tb/tb_and_delay_meter.sv
module tb_and_delay_meter;
    import and_delay_meter_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] ro_in_a = '0;
    logic [11:0] ro_in_b = '0;
    logic [11:0] ro_en_a;
    logic [11:0] ro_en_b;

    int n_tests = 0;
    int n_fail  = 0;

    and_delay_meter_if #(.CNT_W(16), .WIN_W(16)) bus_a ();
    and_delay_meter_if #(.CNT_W(4),  .WIN_W(16)) bus_b ();

    and_delay_meter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(8)) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .ro_in(ro_in_a),
        .ro_en(ro_en_a),
        .bus  (bus_a)
    );

    and_delay_meter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(8)) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .ro_in(ro_in_b),
        .ro_en(ro_en_b),
        .bus  (bus_b)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // 10 MHz oscillator on ro_in_a[4], 25 MHz on ro_in_b[0]
    initial begin
        #5;
        forever #50 ro_in_a[4] = ~ro_in_a[4];
    end
    initial begin
        #5;
        forever #20 ro_in_b[0] = ~ro_in_b[0];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts one request on dut_a and waits for done. sel/window are
    // scrambled right after the start to show they are not re-sampled.
    // A second start is pulsed in cycle inj (if >0) while the run is busy.
    task automatic run_a(input logic [3:0] s, input logic [15:0] w, input int inj,
                         output int lat, output logic [15:0] cnt, output logic ovf,
                         output logic err, output logic [11:0] en_mid, output logic busy1,
                         output logic [11:0] en_done);
        bus_a.sel    = s;
        bus_a.window = w;
        bus_a.start  = 1'b1;
        @(posedge clk); #1;
        bus_a.start  = 1'b0;
        bus_a.sel    = 4'd0;
        bus_a.window = 16'd3;
        lat    = 1;
        en_mid = ro_en_a;
        busy1  = bus_a.busy;
        while (!bus_a.done && lat < 3000) begin
            bus_a.start = (lat == inj);
            @(posedge clk); #1;
            lat++;
            if (lat == 5) en_mid = ro_en_a;
        end
        bus_a.start = 1'b0;
        cnt     = bus_a.count;
        ovf     = bus_a.ovf;
        err     = bus_a.err;
        en_done = ro_en_a;
        $display("[TB] txn sel=%0d win=%0d lat=%0d count=%0d ovf=%0d err=%0d",
                 s, w, lat, cnt, ovf, err);
    endtask

    initial begin
        int          lat;
        logic [15:0] cnt;
        logic        ovf, err, busy1;
        logic [11:0] en_mid, en_done;
        int          n_done;

        bus_a.sel = '0; bus_a.window = '0; bus_a.start = 1'b0;
        bus_b.sel = '0; bus_b.window = '0; bus_b.start = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy",  bus_a.busy,  0);
        check_eq("rst_done",  bus_a.done,  0);
        check_eq("rst_count", bus_a.count, 0);
        check_eq("rst_err",   bus_a.err,   0);
        check_eq("rst_ro_en", ro_en_a,     0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 10 MHz on variant 4, window 1000, extra starts at cycle 3 and at done
        run_a(4'd4, 16'd1000, 3, lat, cnt, ovf, err, en_mid, busy1, en_done);
        check_eq("lat_1000",     lat, 1010);
        check_eq("cnt_200_pm1",  (cnt >= 199 && cnt <= 201), 1);
        check_eq("ovf_1000",     ovf, 0);
        check_eq("err_1000",     err, 0);
        check_eq("ro_en_run",    en_mid, 12'h010);
        check_eq("busy_cyc1",    busy1, 1);
        check_eq("ro_en_done",   en_done, 0);
        check_eq("busy_at_done", bus_a.busy, 0);
        // start in the done cycle must be ignored
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        check_eq("ign_done_busy", bus_a.busy, 0);
        check_eq("ign_done_done", bus_a.done, 0);

        // Invalid select, issued one cycle after done: accepted and rejected
        run_a(4'd13, 16'd50, -1, lat, cnt, ovf, err, en_mid, busy1, en_done);
        check_eq("lat_bad_sel",   lat, 1);
        check_eq("err_bad_sel",   err, 1);
        check_eq("cnt_bad_sel",   cnt, 0);
        check_eq("ro_en_bad_sel", en_mid, 0);
        check_eq("busy_bad_sel",  busy1, 0);
        @(posedge clk); #1;

        // Empty window
        run_a(4'd4, 16'd0, -1, lat, cnt, ovf, err, en_mid, busy1, en_done);
        check_eq("lat_win0", lat, 10);
        check_eq("cnt_win0", cnt, 0);
        check_eq("err_win0", err, 0);
        @(posedge clk); #1;

        // Short run so count is nonzero before the reset test
        run_a(4'd4, 16'd50, -1, lat, cnt, ovf, err, en_mid, busy1, en_done);
        check_eq("lat_win50", lat, 60);
        check_eq("cnt_10_pm1", (cnt >= 9 && cnt <= 11), 1);

        // Saturation on the 4-bit instance
        bus_b.sel = PA_H1; bus_b.window = 16'd100; bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start = 1'b0;
        lat = 1;
        while (!bus_b.done && lat < 500) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("[TB] txn dut_b sel=0 win=100 lat=%0d count=%0d ovf=%0d", lat, bus_b.count, bus_b.ovf);
        check_eq("lat_sat", lat, 110);
        check_eq("cnt_sat", bus_b.count, 15);
        check_eq("ovf_sat", bus_b.ovf, 1);

        // Reset in the middle of MEASURE
        @(posedge clk); #1;
        bus_a.sel = 4'd4; bus_a.window = 16'd1000; bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
        repeat (300) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy",  bus_a.busy,  0);
        check_eq("abort_count", bus_a.count, 0);
        check_eq("abort_ro_en", ro_en_a,     0);
        check_eq("abort_done",  bus_a.done,  0);
        n_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus_a.done) n_done++;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus_a.done) n_done++;
        end
        check_eq("abort_no_done", n_done, 0);

        // Fresh measurement after reset
        run_a(4'd4, 16'd100, -1, lat, cnt, ovf, err, en_mid, busy1, en_done);
        check_eq("lat_after_rst", lat, 110);
        check_eq("cnt_after_rst", (cnt >= 19 && cnt <= 21), 1);
        check_eq("err_after_rst", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
